// File: rtl/load_store_unit.sv
// Load/store unit: one core request at a time against a word-addressed memory with a combinational read port.
// Latency: loads and word stores respond 2 cycles after accept; byte and half stores respond after 3 (read-modify-write).
// Backpressure: accepts only in IDLE, and holds the response stable until resp_ready is high.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   req_*              core request (valid/ready): store flag, size, unsigned flag, byte address, right-aligned write data
//   resp_*             core response (valid/ready): extended load data (0 for stores), misalignment error
//   mem_*              word index, write data and write strobe out; combinational read data in
//
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses through resp_err
// without touching memory. Without it, the misaligned low address bits are cleared and the access proceeds.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_store;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_mis;
  logic [31:0] r_merge;

  logic        w_misalign;
  logic [31:0] w_aligned_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_word;

  // size 11 behaves exactly like a word access
  assign w_word = r_size[1];

  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  // Non-trap mode: drop the offending low bits so the access lands on its natural boundary
  assign w_aligned_addr = {req_addr[31:2],
                           req_size[1] ? 1'b0 : req_addr[1],
                           (req_size == 2'b00) ? req_addr[0] : 1'b0};

  // Little-endian lane extraction from the addressed word
  always_comb begin
    w_byte = mem_read_data[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = mem_read_data[7:0];
      2'd1: w_byte = mem_read_data[15:8];
      2'd2: w_byte = mem_read_data[23:16];
      2'd3: w_byte = mem_read_data[31:24];
      default: w_byte = mem_read_data[7:0];
    endcase
    w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    w_load_data = mem_read_data;
    if (r_size == 2'b00)
      w_load_data = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
    else if (r_size == 2'b01)
      w_load_data = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
  end

  // Replace only the addressed lanes of the captured old word
  always_comb begin
    w_merged = r_merge;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = r_merge;
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_store    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_mis      <= 1'b0;
      r_merge    <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store    <= req_store;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= TRAP_EN ? req_addr : w_aligned_addr;
            r_wdata    <= req_wdata;
            r_mis      <= TRAP_EN & w_misalign;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
          end
        end
        S_ACCESS: begin
          if (r_mis) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end else if (!r_store) begin
            r_rdata <= w_load_data;
          end else begin
            r_rdata <= 32'd0;
            if (!w_word) r_merge <= mem_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = 32'd0;
    mem_address    = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (!r_mis) mem_address = {2'b00, r_addr[31:2]};
        if (r_mis || !r_store) begin
          w_next = S_RESP;
        end else if (w_word) begin
          mem_write      = 1'b1;
          mem_write_data = r_wdata;
          w_next         = S_RESP;
        end else begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_address    = {2'b00, r_addr[31:2]};
        mem_write      = 1'b1;
        mem_write_data = w_merged;
        w_next         = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset overrides everything combinationally so an in-flight operation can never write or respond
    if (reset) begin
      req_ready      = 1'b1;
      resp_valid     = 1'b0;
      mem_write      = 1'b0;
      mem_write_data = 32'd0;
      mem_address    = 32'd0;
    end
  end

  assign resp_rdata = reset ? 32'd0 : r_rdata;
  assign resp_err   = reset ? 1'b0 : r_err;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:15];
  int          wr_cnt = 0;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[3:0]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[3:0]] = mem_write_data;
      wr_cnt++;
    end
  end

`define CHK(tag, obs, exp) begin n_chk++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s observed=0x%0h expected=0x%0h", tag, (obs), (exp)); end end

  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    `CHK("req_ready_before_accept", req_ready, 1'b1)
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until resp_valid; records mem_address in the first (ACCESS) cycle
  task automatic wait_resp(output int lat, output logic [31:0] acc_addr);
    lat = 0;
    acc_addr = 32'hDEAD_DEAD;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) acc_addr = mem_address;
      if (resp_valid) break;
    end
    n_chk++;
    if (resp_valid !== 1'b1) begin
      n_fail++;
      $error("FAIL resp_valid_within_budget: no response after %0d cycles", lat);
    end
  endtask

  task automatic finish_resp();
    @(posedge clk);
    @(negedge clk);
    `CHK("back_to_idle_req_ready", req_ready, 1'b1)
    `CHK("back_to_idle_resp_valid", resp_valid, 1'b0)
  endtask

  int          lat;
  int          wr0;
  logic [31:0] acc;
  logic [31:0] held;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    n_chk++;
    if ({req_ready, resp_valid, resp_err, mem_write, resp_rdata, mem_address, mem_write_data}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $error("FAIL reset_state: req_ready=%b resp_valid=%b resp_err=%b mem_write=%b resp_rdata=0x%0h mem_address=0x%0h mem_write_data=0x%0h",
             req_ready, resp_valid, resp_err, mem_write, resp_rdata, mem_address, mem_write_data);
    end
    `CHK("rst_req_ready", req_ready, 1'b1)
    `CHK("rst_resp_valid", resp_valid, 1'b0)
    `CHK("rst_resp_err", resp_err, 1'b0)
    `CHK("rst_mem_write", mem_write, 1'b0)
    `CHK("rst_resp_rdata", resp_rdata, 32'd0)
    `CHK("rst_mem_address", mem_address, 32'd0)
    `CHK("rst_mem_write_data", mem_write_data, 32'd0)
    reset = 1'b0;
    mem[5] = 32'h8899AABB;
    mem[2] = 32'h11223344;
    mem[15] = 32'h0BADBEEF;

    // Word load
    wr0 = wr_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
    wait_resp(lat, acc);
    `CHK("lw_latency", lat, 2)
    `CHK("lw_access_addr", acc, 32'd5)
    `CHK("lw_rdata", resp_rdata, 32'h8899AABB)
    `CHK("lw_err", resp_err, 1'b0)
    `CHK("lw_no_write", wr_cnt, wr0)
    finish_resp();

    // Sub-word loads
    issue(1'b0, 2'b00, 1'b0, 32'h17, 32'd0);
    wait_resp(lat, acc);
    `CHK("lb_rdata", resp_rdata, 32'hFFFFFF88)
    finish_resp();
    issue(1'b0, 2'b00, 1'b1, 32'h17, 32'd0);
    wait_resp(lat, acc);
    `CHK("lbu_rdata", resp_rdata, 32'h00000088)
    finish_resp();
    issue(1'b0, 2'b01, 1'b0, 32'h16, 32'd0);
    wait_resp(lat, acc);
    `CHK("lh_rdata", resp_rdata, 32'hFFFF8899)
    finish_resp();
    issue(1'b0, 2'b01, 1'b1, 32'h14, 32'd0);
    wait_resp(lat, acc);
    `CHK("lhu_rdata", resp_rdata, 32'h0000AABB)
    finish_resp();
    issue(1'b0, 2'b00, 1'b0, 32'h15, 32'd0);
    wait_resp(lat, acc);
    `CHK("lb_lane1_rdata", resp_rdata, 32'hFFFFFFAA)
    finish_resp();

    // Byte store
    wr0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AB);
    wait_resp(lat, acc);
    `CHK("sb_latency", lat, 3)
    `CHK("sb_single_write", wr_cnt - wr0, 1)
    `CHK("sb_mem", mem[2], 32'h1122AB44)
    `CHK("sb_rdata_zero", resp_rdata, 32'd0)
    finish_resp();

    // Half store on the upper half
    mem[2] = 32'h11223344;
    issue(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000BEEF);
    wait_resp(lat, acc);
    `CHK("sh_latency", lat, 3)
    `CHK("sh_mem", mem[2], 32'hBEEF3344)
    finish_resp();

    // Byte store to lane 3 only uses wdata[7:0]
    mem[2] = 32'h11223344;
    issue(1'b1, 2'b00, 1'b0, 32'h0B, 32'h12345677);
    wait_resp(lat, acc);
    `CHK("sb_lane3_mem", mem[2], 32'h77223344)
    finish_resp();

    // Word store
    wr0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFEF00D);
    wait_resp(lat, acc);
    `CHK("sw_latency", lat, 2)
    `CHK("sw_single_write", wr_cnt - wr0, 1)
    `CHK("sw_mem", mem[2], 32'hCAFEF00D)
    finish_resp();

    // Backpressure on the response
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
    wait_resp(lat, acc);
    held = resp_rdata;
    `CHK("bp_first_rdata", held, 32'h8899AABB)
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      `CHK("bp_resp_valid_held", resp_valid, 1'b1)
      `CHK("bp_rdata_stable", resp_rdata, held)
      `CHK("bp_req_ready_low", req_ready, 1'b0)
    end
    resp_ready = 1'b1;
    finish_resp();

    // Reset while in WRITE during a byte store
    mem[2] = 32'h11223344;
    wr0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AB);
    @(negedge clk);
    @(negedge clk);
    `CHK("rstw_in_write_strobe", mem_write, 1'b1)
    reset = 1'b1;
    #1;
    `CHK("rstw_write_gated", mem_write, 1'b0)
    `CHK("rstw_write_data_zero", mem_write_data, 32'd0)
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    `CHK("rstw_req_ready_next", req_ready, 1'b1)
    `CHK("rstw_no_resp", resp_valid, 1'b0)
    @(negedge clk);
    `CHK("rstw_still_no_resp", resp_valid, 1'b0)
    `CHK("rstw_mem_unchanged", mem[2], 32'h11223344)
    `CHK("rstw_no_write", wr_cnt, wr0)

    // Misaligned word load
    wr0 = wr_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h16, 32'd0);
    wait_resp(lat, acc);
    `CHK("mis_latency", lat, 2)
`ifdef LSU_MISALIGN_TRAP_EN
    `CHK("mis_trap_err", resp_err, 1'b1)
    `CHK("mis_trap_rdata", resp_rdata, 32'd0)
    `CHK("mis_trap_no_access", acc, 32'd0)
`else
    `CHK("mis_err", resp_err, 1'b0)
    `CHK("mis_rdata", resp_rdata, 32'h8899AABB)
    `CHK("mis_access_addr", acc, 32'd5)
`endif
    `CHK("mis_no_write", wr_cnt, wr0)
    finish_resp();
    `CHK("mis_err_cleared_next", resp_err === 1'b1 && resp_valid === 1'b1, 1'b0)

    // Top-of-address-space wrap
    issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'd0);
    wait_resp(lat, acc);
    `CHK("wrap_access_addr", acc, 32'h3FFFFFFF)
    `CHK("wrap_rdata", resp_rdata, 32'h0BADBEEF)
    finish_resp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
